// File: rtl/param_sequence_generator_pkg.sv
// Shared mode encodings, ping-pong direction type and the length/restart helpers
// used by the table-driven sequence generator.
package seq_gen_pkg;

  localparam logic [1:0] MODE_WRAP     = 2'b00;
  localparam logic [1:0] MODE_PINGPONG = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;

  typedef enum logic {
    PP_FWD = 1'b0,
    PP_REV = 1'b1
  } pp_dir_e;

  // Active length: 0 acts as 1, anything past the table acts as the full table.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    if (len == 0) return 1;
    if (len > depth) return depth;
    return len;
  endfunction

  // Reverse start only makes sense where dir is honoured; ping-pong always starts at 0.
  function automatic int unsigned restart_pos(input int unsigned l, input logic dir,
                                              input logic [1:0] mode);
    return (dir && mode != MODE_PINGPONG) ? l - 1 : 0;
  endfunction

endpackage

// File: rtl/param_sequence_generator_seq_table.sv
// DEPTH x WIDTH pattern table: synchronous write, asynchronous read,
// reset loads each entry with its own index.
module seq_table #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;

  // Addresses at or above DEPTH match no entry, so they are dropped here.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    always_ff @(posedge clk_i) begin
      if (reset_i)
        mem_q[g] <= WIDTH'(g);
      else if (wr_en_i && wr_addr_i == AW'(g))
        mem_q[g] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/param_sequence_generator.sv
// Table-driven sequence generator: index FSM with wrap, ping-pong and one-shot
// stepping over a programmable active length, reading a writable pattern table.
module param_sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic [LW-1:0]    len_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] seq_out_o,
  output logic [AW-1:0]    idx_o,
  output logic             wrap_o,
  output logic             done_o
);

  logic [AW-1:0] idx_q, idx_d;
  pp_dir_e       pp_q, pp_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;

  logic [LW-1:0] len_l;
  logic [AW-1:0] last, rst_pos;
  logic          oneshot, go_fwd;

  assign len_l   = LW'(clamp_len(32'(len_i), DEPTH));
  assign last    = AW'(len_l - 1'b1);
  assign rst_pos = AW'(restart_pos(32'(len_l), dir_i, mode_i));
  assign oneshot = (mode_i == MODE_ONESHOT);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q  <= '0;
      pp_q   <= PP_FWD;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      pp_q   <= pp_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    idx_d  = idx_q;
    pp_d   = pp_q;
    wrap_d = 1'b0;
    done_d = done_q;
    go_fwd = 1'b1;
    if (restart_i) begin
      idx_d  = rst_pos;
      pp_d   = PP_FWD;
      done_d = 1'b0;
    end else if (en_i) begin
      if (oneshot && done_q) begin
        idx_d = idx_q;
      end else if (idx_q > last) begin
        // Length shrank under us: silently re-home, no end-of-sequence event.
        idx_d = rst_pos;
      end else if (last == '0) begin
        idx_d  = '0;
        wrap_d = 1'b1;
        if (oneshot) done_d = 1'b1;
      end else begin
        case (mode_i)
          MODE_PINGPONG: begin
            // Bounce if the flag points off the end (e.g. after a re-home).
            go_fwd = (pp_q == PP_FWD) ? (idx_q != last) : (idx_q == '0);
            idx_d  = go_fwd ? idx_q + 1'b1 : idx_q - 1'b1;
            if (go_fwd ? (idx_d == last) : (idx_d == '0)) begin
              wrap_d = 1'b1;
              pp_d   = go_fwd ? PP_REV : PP_FWD;
            end else begin
              pp_d   = go_fwd ? PP_FWD : PP_REV;
            end
          end
          MODE_ONESHOT: begin
            if (dir_i ? (idx_q == '0) : (idx_q == last)) begin
              wrap_d = 1'b1;
              done_d = 1'b1;
            end else begin
              idx_d = dir_i ? idx_q - 1'b1 : idx_q + 1'b1;
              if (dir_i ? (idx_d == '0) : (idx_d == last)) begin
                wrap_d = 1'b1;
                done_d = 1'b1;
              end
            end
          end
          default: begin
            if (!dir_i) begin
              if (idx_q == last) begin
                idx_d  = '0;
                wrap_d = 1'b1;
              end else begin
                idx_d  = idx_q + 1'b1;
              end
            end else begin
              if (idx_q == '0) begin
                idx_d  = last;
                wrap_d = 1'b1;
              end else begin
                idx_d  = idx_q - 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  seq_table #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_table (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .wr_en_i  (wr_en_i),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .rd_addr_i(idx_q),
    .rd_data_o(seq_out_o)
  );

  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;
  assign done_o = done_q;

endmodule

// File: doc/param_sequence_generator.md
# param_sequence_generator

Parametrised, table-driven successor to the fixed 3-bit `sequence_generator`. It steps an index through a programmable table of `DEPTH` entries, each `WIDTH` bits wide, and drives the selected entry on `seq_out`. It supports forward/reverse stepping, wrap, ping-pong and one-shot modes, a runtime-selectable active length, and in-place table writes. It sits wherever the design needs a repeating or single-pass code pattern (pattern source, mux select sequencing, test stimulus).

## Interface
- `WIDTH`, 3: bits per table entry and per `seq_out`.
- `DEPTH`, 8: table entries; legal range 2..256. `AW = $clog2(DEPTH)`; `LW = $clog2(DEPTH+1)`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: advance one step on this edge.
- `restart` in 1: return to start position, clear `done`.
- `dir` in 1: 0 forward, 1 reverse. Used in wrap and one-shot modes.
- `mode` in 2: 00 wrap, 01 ping-pong, 10 one-shot, 11 treated as wrap.
- `len` in LW: active length. 0 is treated as 1; values above `DEPTH` are treated as `DEPTH`. Call the result `L`.
- `wr_en` in 1: table write strobe.
- `wr_addr` in AW: table write address. Addresses at or above `DEPTH` are ignored.
- `wr_data` in WIDTH: table write data.
- `seq_out` out WIDTH: `table[idx]`, combinational read of registered state.
- `idx` out AW: current index.
- `wrap` out 1: one-cycle pulse on end-of-sequence event.
- `done` out 1: one-shot finished; sticky.

## Operation
- Reset values: `idx`=0, `wrap`=0, `done`=0, ping-pong direction flag=forward, `table[i]` = i mod 2^WIDTH. So `seq_out`=0 after reset, and the default table behaves as an up-counter.
- Priority on each edge: `reset` > `restart` > `en`. Table writes are independent of all three except `reset`, which wins over `wr_en`.
- Restart position: `L-1` if `dir`=1 and mode is wrap/one-shot; otherwise 0. `restart` also clears `done`, clears `wrap`, and sets the ping-pong flag to forward.
- Wrap mode, forward: `idx` goes `L-1`→0; `wrap` pulses on that edge. Reverse: 0→`L-1`; `wrap` pulses.
- Ping-pong mode: `dir` is ignored and the internal flag is used. On reaching index `L-1` (forward) or 0 (reverse), the flag flips and `wrap` pulses on the edge that lands on the end index. The sequence for `L`=4 is 0,1,2,3,2,1,0,1…
- One-shot mode: steps toward the end index (`L-1` forward, 0 reverse). On the edge that lands on the end index, `done`=1 and `wrap` pulses. Once `done`=1, `en` has no effect until `restart` or `reset`.
- `L`=1: `idx` stays at 0. Every enabled step pulses `wrap`, and in one-shot mode the first enabled step sets `done`.
- `len` shrinking below `idx+1` while running: the next enabled step moves `idx` to the restart position. No `wrap` pulse is generated for this move.
- `dir` or `mode` change mid-sequence takes effect on the next enabled step, from the current `idx`. Entering ping-pong keeps the flag's current value.
- `wrap` is 0 on every edge that does not generate a pulse, including any edge with `en`=0.

## Timing
- `idx`, `wrap` and `done` are registered and update on the same edge. `seq_out` reflects the new `idx` in that cycle.
- Stepping latency is one cycle: with `en` high, `idx` changes on every edge. `en` is sampled only at the edge.
- Write latency is one cycle: a write to `table[idx]` is visible on `seq_out` the cycle after `wr_en`. When a write and a step happen on the same edge, `seq_out` shows `table[new idx]` with the write applied.
- The read is combinational, so there is no read latency from `idx` to `seq_out`.

## Structure
- Package `seq_gen_pkg` holds:
  - mode constants `MODE_WRAP`=2'b00, `MODE_PINGPONG`=2'b01, `MODE_ONESHOT`=2'b10;
  - the `L` clamp function;
  - the restart-position function.
- Sub-module `seq_table`: `DEPTH`×`WIDTH` register file with a synchronous write port, asynchronous read, and the reset-to-index init.
- The top level holds the index FSM (`idx`, ping-pong flag, `wrap`, `done`) and instantiates `seq_table`.

## Test plan
- Default parameters, reset, `en`=1, wrap mode, `len`=8, forward → `seq_out` 0..7,0 with `wrap`=1 only on the cycle `seq_out` returns to 0.
- Ping-pong, `len`=4, `en`=1 → `idx` 0,1,2,3,2,1,0,1 with `wrap` pulses when `idx` lands on 3 and on 0.
- One-shot reverse, `len`=5, `restart` then `en`=1 → `idx` 4,3,2,1,0. `done`=1 from `idx`=0 onward and `idx` holds at 0; a subsequent `restart` gives `idx`=4 and `done`=0.
- Table program: write entries 0..3 = 5,3,6,1 with `en`=0, then wrap mode with `len`=4 → `seq_out` 5,3,6,1,5. A write of 7 to the current index is seen on `seq_out` the next cycle.
- Boundaries:
  - `len`=0 → `idx` stays at 0 and `wrap` pulses every enabled cycle.
  - `len`=15 with `DEPTH`=8 → behaves as 8.
  - `len` dropped from 8 to 3 while `idx`=6 → next step gives `idx`=0 with no `wrap` pulse.
- Reset mid-operation, with `wr_en`, `restart` and `en` all high on the same edge → next cycle `idx`=0, `wrap`=0, `done`=0, table restored to its index values, and the write is discarded.
